// File: rtl/food_placer.sv
// Apple placement controller: samples random grid candidates and scans the snake
// body memory, retrying until a free in-range cell is found or the retry budget runs out.
module food_placer #(
  parameter int unsigned GRID_W    = 80,
  parameter int unsigned GRID_H    = 60,
  parameter int unsigned MAX_RETRY = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] x_start_grid,
  input  logic [5:0] y_start_grid,
  input  logic       place_req,
  input  logic [6:0] snake_length,
  output logic [5:0] seg_addr,
  input  logic [6:0] seg_x,
  input  logic [5:0] seg_y,
  output logic [6:0] apple_x,
  output logic [5:0] apple_y,
  output logic       apple_valid,
  output logic       place_busy,
  output logic       place_fail
);

  typedef enum logic [1:0] {IDLE, SAMPLE, SCAN, FAIL} state_t;

  localparam logic [7:0] MAX_R = 8'(MAX_RETRY);

  state_t     state_r;
  logic [6:0] cand_x_r;
  logic [5:0] cand_y_r;
  logic [6:0] len_r;
  logic [7:0] attempts_r;
  logic       addr_live_r;
  logic       cmp_valid_r;
  logic [5:0] cmp_idx_r;

  logic       last_addr_s;
  logic       hit_s;
  logic       last_cmp_s;
  logic       samp_oor_s;
  logic [7:0] att_next_s;

  function automatic logic out_of_range(input logic [6:0] x, input logic [5:0] y);
    return (32'(x) >= GRID_W) || (32'(y) >= GRID_H);
  endfunction

  // Compare-stage decode: data on seg_x/seg_y belongs to cmp_idx_r when cmp_valid_r is set
  always_comb begin
    last_addr_s = 1'b0;
    hit_s       = 1'b0;
    last_cmp_s  = 1'b0;
    samp_oor_s  = out_of_range(x_start_grid, y_start_grid);
    att_next_s  = attempts_r + 8'd1;
    if (len_r != 7'd0) begin
      last_addr_s = ({1'b0, seg_addr} == (len_r - 7'd1));
    end else begin
      last_addr_s = 1'b1;
    end
    if (cmp_valid_r) begin
      hit_s      = ((seg_x == cand_x_r) && (seg_y == cand_y_r)) ||
                   ((cmp_idx_r == 6'd0) && out_of_range(cand_x_r, cand_y_r));
      last_cmp_s = ({1'b0, cmp_idx_r} == (len_r - 7'd1));
    end else begin
      hit_s      = 1'b0;
      last_cmp_s = 1'b0;
    end
  end

  // Placement FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cand_x_r    <= 7'd0;
      cand_y_r    <= 6'd0;
      len_r       <= 7'd0;
      attempts_r  <= 8'd0;
      addr_live_r <= 1'b0;
      cmp_valid_r <= 1'b0;
      cmp_idx_r   <= 6'd0;
      seg_addr    <= 6'd0;
      apple_x     <= 7'd0;
      apple_y     <= 6'd0;
      apple_valid <= 1'b0;
      place_busy  <= 1'b0;
      place_fail  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          place_fail <= 1'b0;
          if (place_req) begin
            state_r     <= SAMPLE;
            apple_valid <= 1'b0;
            place_busy  <= 1'b1;
            attempts_r  <= 8'd0;
          end else begin
            state_r <= IDLE;
          end
        end
        SAMPLE: begin
          cand_x_r    <= x_start_grid;
          cand_y_r    <= y_start_grid;
          len_r       <= snake_length;
          seg_addr    <= 6'd0;
          attempts_r  <= att_next_s;
          cmp_valid_r <= 1'b0;
          addr_live_r <= (snake_length != 7'd0);
          if (snake_length == 7'd0) begin
            if (!samp_oor_s) begin
              apple_x     <= x_start_grid;
              apple_y     <= y_start_grid;
              apple_valid <= 1'b1;
              place_busy  <= 1'b0;
              state_r     <= IDLE;
            end else if (att_next_s == MAX_R) begin
              place_fail <= 1'b1;
              state_r    <= FAIL;
            end else begin
              state_r <= SAMPLE;
            end
          end else begin
            state_r <= SCAN;
          end
        end
        SCAN: begin
          cmp_valid_r <= addr_live_r;
          cmp_idx_r   <= seg_addr;
          if (addr_live_r && !last_addr_s) begin
            seg_addr <= seg_addr + 6'd1;
          end else begin
            addr_live_r <= 1'b0;
          end
          if (hit_s) begin
            // Drop whatever read is still in flight; SAMPLE restarts the scan
            addr_live_r <= 1'b0;
            cmp_valid_r <= 1'b0;
            if (attempts_r == MAX_R) begin
              place_fail <= 1'b1;
              state_r    <= FAIL;
            end else begin
              state_r <= SAMPLE;
            end
          end else if (last_cmp_s) begin
            apple_x     <= cand_x_r;
            apple_y     <= cand_y_r;
            apple_valid <= 1'b1;
            place_busy  <= 1'b0;
            addr_live_r <= 1'b0;
            cmp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= SCAN;
          end
        end
        FAIL: begin
          place_fail <= 1'b0;
          place_busy <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_food_placer.sv
// Bench for food_placer: directed vector table, reset-abort sequence, and randomized
// requests checked against a cycle-count reference model of the placement rules.
module tb_food_placer;
  localparam int MAXR = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] x_start_grid;
  logic [5:0] y_start_grid;
  logic       place_req;
  logic [6:0] snake_length;
  logic [5:0] seg_addr;
  logic [6:0] seg_x;
  logic [5:0] seg_y;
  logic [6:0] apple_x;
  logic [5:0] apple_y;
  logic       apple_valid;
  logic       place_busy;
  logic       place_fail;

  food_placer #(.GRID_W(80), .GRID_H(60), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .reset(reset), .x_start_grid(x_start_grid), .y_start_grid(y_start_grid),
    .place_req(place_req), .snake_length(snake_length), .seg_addr(seg_addr),
    .seg_x(seg_x), .seg_y(seg_y), .apple_x(apple_x), .apple_y(apple_y),
    .apple_valid(apple_valid), .place_busy(place_busy), .place_fail(place_fail)
  );

  always #5 clk = ~clk;

  // body memory with one-cycle registered read
  logic [6:0] bx[64];
  logic [5:0] by[64];
  always @(posedge clk) begin
    seg_x <= bx[seg_addr];
    seg_y <= by[seg_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;
  int gx[256];
  int gy[256];
  bit samp[256];

  typedef struct {
    int len;
    int b0x, b0y, b1x, b1y, b2x, b2y;
    int fx, fy, rx, ry;
    int ex, ey;
    bit ev;
    int d;
    int a0k;
    bit extra;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // place_req is set in the current cycle; cycle k is the k-th cycle after the sampling edge
  task automatic run_req(input int L, input int ex, input int ey, input bit ev, input int d,
                         input int a0k, input bit extra, input bit scramble);
    place_req    = 1'b1;
    snake_length = 7'(L);
    x_start_grid = 7'(gx[0]);
    y_start_grid = 6'(gy[0]);
    for (int k = 1; k <= d + 2; k++) begin
      @(negedge clk);
      chk("busy", place_busy, 32'(k < d));
      chk("valid", apple_valid, 32'(ev && k >= d));
      chk("fail_pulse", place_fail, 32'(!ev && k == d - 1));
      if (ev && k == d) begin
        chk("apple_x", apple_x, ex);
        chk("apple_y", apple_y, ey);
      end
      if (k == a0k) chk("seg_addr_restart", seg_addr, 0);
      place_req    = extra && ((k == 3 && k < d - 1) || k == d - 1);
      x_start_grid = 7'(gx[k]);
      y_start_grid = 6'(gy[k]);
      snake_length = (scramble && !samp[k]) ? 7'($urandom_range(0, 64)) : 7'(L);
    end
  endtask

  // Reference: attempt n samples the generator in cycle c; a hit at segment i costs 3+i cycles
  task automatic model(input int L, output int ex, output int ey, output bit ev, output int d);
    int c;
    int att;
    bit done;
    c = 1; att = 0; done = 0; ex = 0; ey = 0; ev = 0; d = 0;
    for (int k = 0; k < 256; k++) samp[k] = 0;
    while (!done) begin
      int cx;
      int cy;
      int hit;
      bit oor;
      cx = gx[c]; cy = gy[c]; hit = -1;
      samp[c] = 1;
      att++;
      oor = (cx >= 80) || (cy >= 60);
      if (L == 0) begin
        if (!oor) begin ev = 1; ex = cx; ey = cy; d = c + 1; done = 1; end
        else if (att == MAXR) begin ev = 0; d = c + 2; done = 1; end
        else c = c + 1;
      end else begin
        if (oor) hit = 0;
        else for (int i = L - 1; i >= 0; i--) if (int'(bx[i]) == cx && int'(by[i]) == cy) hit = i;
        if (hit < 0) begin ev = 1; ex = cx; ey = cy; d = c + 2 + L; done = 1; end
        else if (att == MAXR) begin ev = 0; d = c + 4 + hit; done = 1; end
        else c = c + 3 + hit;
      end
    end
  endtask

  initial begin
    int ex, ey, d;
    bit ev;

    tbl[0] = '{3, 10,10, 11,10, 12,10,  40,30, 40,30,  40,30, 1'b1,  6, 2, 1'b1};
    tbl[1] = '{3, 10,10, 11,10, 12,10,  11,10, 50,20,  50,20, 1'b1, 10, 6, 1'b0};
    tbl[2] = '{1,  0, 0, 99,50, 99,50,  85, 5,  3,59,   3,59, 1'b1,  7, 5, 1'b0};
    tbl[3] = '{3, 10,10, 11,10, 12,10,  10,10, 10,10,   0, 0, 1'b0, 14, 11, 1'b0};
    tbl[4] = '{3, 10,10, 11,10, 12,10,  12,10,  0,59,   0,59, 1'b1, 11, 7, 1'b0};
    tbl[5] = '{0, 10,10, 11,10, 12,10,   7, 7,  7, 7,   7, 7, 1'b1,  2, 2, 1'b1};
    tbl[6] = '{0, 10,10, 11,10, 12,10,  80, 0, 79,59,  79,59, 1'b1,  3, 2, 1'b0};
    tbl[7] = '{0, 10,10, 11,10, 12,10,   0,60,  0,60,   0, 0, 1'b0,  6, 2, 1'b0};

    for (int i = 0; i < 64; i++) begin bx[i] = 7'd99; by[i] = 6'd50; end
    reset = 1'b1; place_req = 1'b0; snake_length = 7'd0;
    x_start_grid = 7'd0; y_start_grid = 6'd0;
    repeat (3) @(negedge clk);
    chk("rst_apple_x", apple_x, 0);
    chk("rst_apple_y", apple_y, 0);
    chk("rst_valid", apple_valid, 0);
    chk("rst_busy", place_busy, 0);
    chk("rst_fail", place_fail, 0);
    chk("rst_seg_addr", seg_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 8; t++) begin
      bx[0] = 7'(tbl[t].b0x); by[0] = 6'(tbl[t].b0y);
      bx[1] = 7'(tbl[t].b1x); by[1] = 6'(tbl[t].b1y);
      bx[2] = 7'(tbl[t].b2x); by[2] = 6'(tbl[t].b2y);
      for (int k = 0; k < 256; k++) begin
        gx[k] = (k <= 1) ? tbl[t].fx : tbl[t].rx;
        gy[k] = (k <= 1) ? tbl[t].fy : tbl[t].ry;
        samp[k] = 1;
      end
      run_req(tbl[t].len, tbl[t].ex, tbl[t].ey, tbl[t].ev, tbl[t].d, tbl[t].a0k, tbl[t].extra, 1'b0);
    end

    // reset while scanning a 20-segment body aborts the request
    for (int i = 0; i < 20; i++) begin bx[i] = 7'(20 + i); by[i] = 6'd40; end
    for (int k = 0; k < 256; k++) begin gx[k] = 40; gy[k] = 30; samp[k] = 1; end
    place_req = 1'b1; snake_length = 7'd20; x_start_grid = 7'd40; y_start_grid = 6'd30;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      place_req = 1'b0;
    end
    chk("busy_before_reset", place_busy, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", place_busy, 0);
    chk("abort_valid", apple_valid, 0);
    chk("abort_fail", place_fail, 0);
    chk("abort_seg_addr", seg_addr, 0);
    chk("abort_apple_x", apple_x, 0);
    chk("abort_apple_y", apple_y, 0);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      chk("abort_no_commit", {apple_valid, place_busy, place_fail}, 0);
    end
    run_req(20, 40, 30, 1'b1, 23, 2, 1'b0, 1'b0);

    // randomized requests in a small region so collisions and exhaustion are common
    for (int r = 0; r < 40; r++) begin
      int L;
      L = $urandom_range(0, 8);
      for (int i = 0; i < 64; i++) begin
        bx[i] = 7'($urandom_range(0, 5));
        by[i] = 6'($urandom_range(0, 3));
      end
      for (int k = 0; k < 256; k++) begin
        if ($urandom_range(0, 9) == 0) begin
          gx[k] = $urandom_range(0, 127);
          gy[k] = $urandom_range(0, 63);
        end else begin
          gx[k] = $urandom_range(0, 5);
          gy[k] = $urandom_range(0, 3);
        end
      end
      model(L, ex, ey, ev, d);
      run_req(L, ex, ey, ev, d, -1, r[0], 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
